// File: rtl/alu_seq.sv
// alu_seq: sequential ALU execution unit with valid/ready handshakes on
// both sides. Single-cycle arithmetic/branch ops, and bit-serial logical
// shifts that move one bit per clock.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_inst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             branch_taken,
  output logic             illegal
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SFL = 4'b0010;
  localparam logic [3:0] OP_SFR = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_DEC = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;
  localparam logic [3:0] OP_BLT = 4'b1000;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic             shift_left;

  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_branch;
  logic             nxt_illegal;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   wide_sum;
  logic [SHW-1:0]   shamt;
  logic             is_shift;

  assign in_ready = (state == IDLE);
  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (alu_inst == OP_SFL) || (alu_inst == OP_SFR);
  assign diff     = op_a - op_b;

  // Single-cycle result, flags and illegal decode for the offered command
  always_comb begin
    nxt_result  = '0;
    nxt_carry   = 1'b0;
    nxt_branch  = 1'b0;
    nxt_illegal = 1'b0;
    wide_sum    = '0;
    case (alu_inst)
      OP_ADD: begin
        wide_sum   = {1'b0, op_a} + {1'b0, op_b};
        nxt_result = wide_sum[WIDTH-1:0];
        nxt_carry  = wide_sum[WIDTH];
      end
      OP_SUB: begin
        nxt_result = diff;
        nxt_carry  = (op_a < op_b);
      end
      // Only reached as a result for shift-by-0; non-zero shifts run serially
      OP_SFL, OP_SFR: nxt_result = op_a;
      OP_INC: begin
        wide_sum   = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1};
        nxt_result = wide_sum[WIDTH-1:0];
        nxt_carry  = wide_sum[WIDTH];
      end
      OP_DEC: begin
        nxt_result = op_a - {{(WIDTH-1){1'b0}}, 1'b1};
        nxt_carry  = (op_a == '0);
      end
      OP_BNE: begin
        nxt_result = diff;
        nxt_branch = (op_a != op_b);
      end
      OP_BEQ: begin
        nxt_result = diff;
        nxt_branch = (op_a == op_b);
      end
      OP_BLT: begin
        nxt_result = diff;
        nxt_branch = ($signed(op_a) < $signed(op_b));
      end
      default: nxt_illegal = 1'b1;
    endcase
  end

  // Control FSM; result doubles as the shift working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shift_left   <= 1'b0;
      result       <= '0;
      carry        <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            branch_taken <= nxt_branch;
            illegal      <= nxt_illegal;
            if (is_shift && (shamt != '0)) begin
              state      <= SHIFT;
              result     <= op_a;
              carry      <= 1'b0;
              cnt        <= shamt;
              shift_left <= (alu_inst == OP_SFL);
            end else begin
              state     <= DONE;
              result    <= nxt_result;
              carry     <= nxt_carry;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (shift_left) begin
            {carry, result} <= {result, 1'b0};
          end else begin
            {result, carry} <= {1'b0, result};
          end
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
